// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: FSM encodings, layer-word field
// positions and activation-function codes.
package layer_sequencer_pkg;

  localparam int MAXC   = 4;
  localparam int WORD_W = 13;

  // Layer configuration word layout
  localparam int NEUR_MSB = 12;
  localparam int NEUR_LSB = 8;
  localparam int BIAS_BIT = 7;
  localparam int FA_MSB   = 6;
  localparam int FA_LSB   = 5;
  localparam int ENT_MSB  = 4;
  localparam int ENT_LSB  = 0;

  localparam logic [1:0] FA_LINEAR  = 2'd0;
  localparam logic [1:0] FA_RELU    = 2'd1;
  localparam logic [1:0] FA_SIGMOID = 2'd2;
  localparam logic [1:0] FA_TANH    = 2'd3;

  // NEXT is the one-cycle layer-entry step: it skips empty layers and
  // detects the end of the layer list.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_BIAS = 3'd3;
  localparam logic [2:0] S_ACT  = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_FIM  = 3'd6;

endpackage

// File: rtl/layer_cfg_unpack.sv
// Splits one 13-bit layer configuration word into its fields.
module layer_cfg_unpack
  import layer_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [4:0]        ent,
  output logic [4:0]        neur,
  output logic              bias,
  output logic [1:0]        fa
);

  assign ent  = word[ENT_MSB:ENT_LSB];
  assign neur = word[NEUR_MSB:NEUR_LSB];
  assign bias = word[BIAS_BIT];
  assign fa   = word[FA_MSB:FA_LSB];

endmodule

// File: rtl/layer_sequencer.sv
// Walks every layer/neuron/input of the latched configuration and emits a
// registered MAC/bias/activation strobe stream, stalling on iPronto=0.
module layer_sequencer #(
  parameter int AW   = 10,
  parameter int MAXC = layer_sequencer_pkg::MAXC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [13*MAXC-1:0]  iDados,
  input  logic                iOK,
  input  logic [2:0]          iQtdCamadas,
  input  logic                iPronto,
  output logic [AW-1:0]       oEndPeso,
  output logic [4:0]          oIdxEntrada,
  output logic [4:0]          oIdxNeuronio,
  output logic [1:0]          oCamada,
  output logic                oMacEn,
  output logic                oMacClr,
  output logic                oBiasEn,
  output logic                oNeurFim,
  output logic [1:0]          oFA,
  output logic                oOcupado,
  output logic                oFim
);
  import layer_sequencer_pkg::*;

  logic [2:0]        state;
  logic [2:0]        layer;
  logic [2:0]        qtd;
  logic [4:0]        neur;
  logic [4:0]        inp;
  logic [AW-1:0]     addr;
  logic [WORD_W-1:0] cfg_q [MAXC];

  logic [WORD_W-1:0] cur_word;
  logic [4:0]        c_ent;
  logic [4:0]        c_neur;
  logic              c_bias;
  logic [1:0]        c_fa;
  logic [2:0]        qtd_eff;
  logic              skip;
  logic [2:0]        enter_state;

  // In LOAD the words are not latched yet, so layer 0 is decoded straight
  // from the input bus; afterwards the latched copy is used.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cur_word = '0;
    if (state == S_LOAD) begin
      cur_word = iDados[WORD_W-1:0];
    end else begin
      for (int k = 0; k < MAXC; k++)
        if (layer == 3'(k)) cur_word = cfg_q[k];
    end
  end

  layer_cfg_unpack u_unpack (
    .word (cur_word),
    .ent  (c_ent),
    .neur (c_neur),
    .bias (c_bias),
    .fa   (c_fa)
  );

  always_comb begin
    qtd_eff = qtd;
    if (state == S_LOAD)
      qtd_eff = (iQtdCamadas > 3'(MAXC)) ? 3'(MAXC) : iQtdCamadas;
  end

  assign skip = (c_neur == 5'd0) || ((c_ent == 5'd0) && !c_bias);

  // Where to go when entering the layer indexed by 'layer'
  always_comb begin
    enter_state = S_MAC;
    if (layer >= qtd_eff)    enter_state = S_FIM;
    else if (skip)           enter_state = S_NEXT;
    else if (c_ent == 5'd0)  enter_state = S_BIAS;
  end

  // NOTE: the configuration array is plain storage written only in LOAD and
  // never read before that, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD)
      for (int k = 0; k < MAXC; k++) cfg_q[k] <= iDados[k*WORD_W +: WORD_W];
  end

  // NOTE: all state and output registers use non-blocking assignments so
  // every branch reads the pre-edge values of the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      layer        <= '0;
      qtd          <= '0;
      neur         <= '0;
      inp          <= '0;
      addr         <= '0;
      oEndPeso     <= '0;
      oIdxEntrada  <= '0;
      oIdxNeuronio <= '0;
      oCamada      <= '0;
      oMacEn       <= 1'b0;
      oMacClr      <= 1'b0;
      oBiasEn      <= 1'b0;
      oNeurFim     <= 1'b0;
      oFA          <= '0;
      oOcupado     <= 1'b0;
      oFim         <= 1'b0;
    end else if (iPronto) begin
      // Outputs show the term produced at this edge; a stall freezes it.
      oMacEn   <= 1'b0;
      oMacClr  <= 1'b0;
      oBiasEn  <= 1'b0;
      oNeurFim <= 1'b0;
      oFA      <= '0;
      oOcupado <= 1'b0;
      oFim     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iOK) begin
            state        <= S_LOAD;
            layer        <= '0;
            neur         <= '0;
            inp          <= '0;
            addr         <= '0;
            oEndPeso     <= '0;
            oIdxEntrada  <= '0;
            oIdxNeuronio <= '0;
            oCamada      <= '0;
          end
        end
        S_LOAD, S_NEXT: begin
          oOcupado <= 1'b1;
          state    <= enter_state;
          if (state == S_LOAD) qtd <= qtd_eff;
          if (enter_state == S_NEXT)     layer   <= layer + 3'd1;
          else if (enter_state != S_FIM) oCamada <= layer[1:0];
        end
        S_MAC: begin
          oMacEn       <= 1'b1;
          oMacClr      <= (inp == 5'd0);
          oEndPeso     <= addr;
          oIdxEntrada  <= inp;
          oIdxNeuronio <= neur;
          oCamada      <= layer[1:0];
          oOcupado     <= 1'b1;
          addr         <= addr + 1'b1;
          if (inp == c_ent - 5'd1) begin
            inp   <= '0;
            state <= c_bias ? S_BIAS : S_ACT;
          end else begin
            inp <= inp + 5'd1;
          end
        end
        S_BIAS: begin
          oMacEn       <= 1'b1;
          oBiasEn      <= 1'b1;
          oMacClr      <= (c_ent == 5'd0);
          oEndPeso     <= addr;
          oIdxEntrada  <= inp;
          oIdxNeuronio <= neur;
          oCamada      <= layer[1:0];
          oOcupado     <= 1'b1;
          addr         <= addr + 1'b1;
          state        <= S_ACT;
        end
        S_ACT: begin
          oNeurFim     <= 1'b1;
          oFA          <= c_fa;
          oIdxNeuronio <= neur;
          oCamada      <= layer[1:0];
          oOcupado     <= 1'b1;
          if (neur == c_neur - 5'd1) begin
            neur  <= '0;
            layer <= layer + 3'd1;
            state <= S_NEXT;
          end else begin
            neur  <= neur + 5'd1;
            state <= (c_ent == 5'd0) ? S_BIAS : S_MAC;
          end
        end
        S_FIM: begin
          oFim <= 1'b1;
          if (!iOK) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed, table-driven bench for layer_sequencer: each row drives the inputs
// for one clock edge and lists the outputs expected right after that edge.
module tb_layer_sequencer;
  import layer_sequencer_pkg::*;

  localparam int AW = 10;
  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [13*NL-1:0] iDados;
  logic            iOK;
  logic [2:0]      iQtdCamadas;
  logic            iPronto;
  logic [AW-1:0]   oEndPeso;
  logic [4:0]      oIdxEntrada;
  logic [4:0]      oIdxNeuronio;
  logic [1:0]      oCamada;
  logic            oMacEn, oMacClr, oBiasEn, oNeurFim, oOcupado, oFim;
  logic [1:0]      oFA;

  always #5 clk = ~clk;

  layer_sequencer #(.AW(AW), .MAXC(NL)) dut (
    .clk          (clk),
    .rst          (rst),
    .iDados       (iDados),
    .iOK          (iOK),
    .iQtdCamadas  (iQtdCamadas),
    .iPronto      (iPronto),
    .oEndPeso     (oEndPeso),
    .oIdxEntrada  (oIdxEntrada),
    .oIdxNeuronio (oIdxNeuronio),
    .oCamada      (oCamada),
    .oMacEn       (oMacEn),
    .oMacClr      (oMacClr),
    .oBiasEn      (oBiasEn),
    .oNeurFim     (oNeurFim),
    .oFA          (oFA),
    .oOcupado     (oOcupado),
    .oFim         (oFim)
  );

  typedef struct {
    logic          rst, ok, pronto;
    logic          zero;
    logic          mac_en, mac_clr, bias_en, neur_fim, ocup, fim;
    logic [1:0]    fa;
    logic [AW-1:0] addr;
    logic [4:0]    ent, neur;
    logic [1:0]    cam;
  } vec_t;

  vec_t vecs[64];
  int   nvec;
  logic cur_rst, cur_ok, cur_pronto;
  int   checks, failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] mk(input int n, input int b, input int fa, input int e);
    return {n[4:0], b[0], fa[1:0], e[4:0]};
  endfunction

  task automatic add(input int zero, input int mac_en, input int clr, input int bias,
                     input int nfim, input int fa, input int ocup, input int fim,
                     input int addr, input int ent, input int neur, input int cam);
    vecs[nvec].rst      = cur_rst;
    vecs[nvec].ok       = cur_ok;
    vecs[nvec].pronto   = cur_pronto;
    vecs[nvec].zero     = (zero != 0);
    vecs[nvec].mac_en   = (mac_en != 0);
    vecs[nvec].mac_clr  = (clr != 0);
    vecs[nvec].bias_en  = (bias != 0);
    vecs[nvec].neur_fim = (nfim != 0);
    vecs[nvec].fa       = fa[1:0];
    vecs[nvec].ocup     = (ocup != 0);
    vecs[nvec].fim      = (fim != 0);
    vecs[nvec].addr     = addr[AW-1:0];
    vecs[nvec].ent      = ent[4:0];
    vecs[nvec].neur     = neur[4:0];
    vecs[nvec].cam      = cam[1:0];
    nvec++;
  endtask

  task automatic v_zero();  add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic v_idle();  add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic v_busy();  add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic v_fim();   add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic v_mac(input int a, input int e, input int n, input int c);
    add(0, 1, (e == 0) ? 1 : 0, 0, 0, 0, 1, 0, a, e, n, c);
  endtask
  task automatic v_bias(input int a, input int clr, input int n, input int c);
    add(0, 1, clr, 1, 0, 0, 1, 0, a, 0, n, c);
  endtask
  task automatic v_act(input int fa, input int n, input int c);
    add(0, 0, 0, 0, 1, fa, 1, 0, 0, 0, n, c);
  endtask

  // Two reset edges, then release reset with iOK still low.
  task automatic start_rows();
    cur_rst = 1'b1; cur_ok = 1'b0; cur_pronto = 1'b1;
    v_zero(); v_zero();
    cur_rst = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    logic [7:0] s_act, s_exp;
    for (int i = 0; i < nvec; i++) begin
      rst = vecs[i].rst; iOK = vecs[i].ok; iPronto = vecs[i].pronto;
      @(posedge clk); #1;
      s_act = {oMacEn, oMacClr, oBiasEn, oNeurFim, oFA, oOcupado, oFim};
      s_exp = {vecs[i].mac_en, vecs[i].mac_clr, vecs[i].bias_en, vecs[i].neur_fim,
               vecs[i].fa, vecs[i].ocup, vecs[i].fim};
      check($sformatf("%s[%0d] strobes{mac,clr,bias,nfim,fa,ocup,fim}", tag, i),
            32'(s_act), 32'(s_exp));
      if (vecs[i].zero)
        check($sformatf("%s[%0d] indices_zero", tag, i),
              32'({oEndPeso, oIdxEntrada, oIdxNeuronio, oCamada}), 32'd0);
      if (vecs[i].mac_en)
        check($sformatf("%s[%0d] addr", tag, i), 32'(oEndPeso), 32'(vecs[i].addr));
      if (vecs[i].mac_en && !vecs[i].bias_en)
        check($sformatf("%s[%0d] input_idx", tag, i), 32'(oIdxEntrada), 32'(vecs[i].ent));
      if (vecs[i].mac_en || vecs[i].neur_fim)
        check($sformatf("%s[%0d] neuron/layer", tag, i),
              32'({oIdxNeuronio, oCamada}), 32'({vecs[i].neur, vecs[i].cam}));
    end
    nvec = 0;
  endtask

  initial begin
    checks = 0; failures = 0; nvec = 0;
    rst = 1'b1; iOK = 1'b0; iPronto = 1'b1;
    iDados = '0; iQtdCamadas = '0;
    cur_rst = 1'b1; cur_ok = 1'b0; cur_pronto = 1'b1;

    // Two layers, full run with no stall
    iDados = {13'd0, 13'd0, mk(1, 0, FA_RELU, 2), mk(2, 1, FA_SIGMOID, 3)};
    iQtdCamadas = 3'd2;
    start_rows();
    cur_ok = 1'b1;
    v_idle(); v_busy();
    v_mac(0, 0, 0, 0); v_mac(1, 1, 0, 0); v_mac(2, 2, 0, 0); v_bias(3, 0, 0, 0);
    v_act(FA_SIGMOID, 0, 0);
    v_mac(4, 0, 1, 0); v_mac(5, 1, 1, 0); v_mac(6, 2, 1, 0); v_bias(7, 0, 1, 0);
    v_act(FA_SIGMOID, 1, 0);
    v_busy();
    v_mac(8, 0, 0, 1); v_mac(9, 1, 0, 1); v_act(FA_RELU, 0, 1);
    v_busy(); v_fim();
    run_vecs("basic");

    // Same config, four stalled cycles while address 5 is presented
    start_rows();
    cur_ok = 1'b1;
    v_idle(); v_busy();
    v_mac(0, 0, 0, 0); v_mac(1, 1, 0, 0); v_mac(2, 2, 0, 0); v_bias(3, 0, 0, 0);
    v_act(FA_SIGMOID, 0, 0);
    v_mac(4, 0, 1, 0); v_mac(5, 1, 1, 0);
    cur_pronto = 1'b0;
    for (int k = 0; k < 4; k++) v_mac(5, 1, 1, 0);
    cur_pronto = 1'b1;
    v_mac(6, 2, 1, 0); v_bias(7, 0, 1, 0); v_act(FA_SIGMOID, 1, 0);
    v_busy();
    v_mac(8, 0, 0, 1); v_mac(9, 1, 0, 1); v_act(FA_RELU, 0, 1);
    v_busy(); v_fim();
    run_vecs("stall");

    // Zero layers: FIM two edges after iOK, then back to IDLE when iOK drops
    iQtdCamadas = 3'd0;
    start_rows();
    cur_ok = 1'b1;
    v_idle(); v_busy(); v_fim(); v_fim();
    cur_ok = 1'b0;
    v_fim(); v_idle();
    run_vecs("count0");

    // Zero inputs with bias; iOK dropped mid-run is ignored
    iDados = {13'd0, 13'd0, 13'd0, mk(2, 1, FA_TANH, 0)};
    iQtdCamadas = 3'd1;
    start_rows();
    cur_ok = 1'b1;
    v_idle();
    cur_ok = 1'b0;
    v_busy();
    v_bias(0, 1, 0, 0); v_act(FA_TANH, 0, 0);
    v_bias(1, 1, 1, 0); v_act(FA_TANH, 1, 0);
    v_busy(); v_fim(); v_idle();
    run_vecs("bias_only");

    // Reset while address 4 is presented, then restart from address 0
    iDados = {13'd0, 13'd0, mk(1, 0, FA_RELU, 2), mk(2, 1, FA_SIGMOID, 3)};
    iQtdCamadas = 3'd2;
    start_rows();
    cur_ok = 1'b1;
    v_idle(); v_busy();
    v_mac(0, 0, 0, 0); v_mac(1, 1, 0, 0); v_mac(2, 2, 0, 0); v_bias(3, 0, 0, 0);
    v_act(FA_SIGMOID, 0, 0); v_mac(4, 0, 1, 0);
    cur_rst = 1'b1; cur_ok = 1'b0;
    v_zero();
    cur_rst = 1'b0;
    v_zero();
    cur_ok = 1'b1;
    v_idle(); v_busy(); v_mac(0, 0, 0, 0); v_mac(1, 1, 0, 0);
    run_vecs("midreset");

    // Layer count 7 clamps to 4; iOK held high after FIM does not restart
    iDados = {mk(1, 0, FA_TANH, 1), mk(1, 0, FA_SIGMOID, 1),
              mk(1, 0, FA_RELU, 1), mk(1, 0, FA_LINEAR, 1)};
    iQtdCamadas = 3'd7;
    start_rows();
    cur_ok = 1'b1;
    v_idle(); v_busy();
    v_mac(0, 0, 0, 0); v_act(FA_LINEAR, 0, 0);  v_busy();
    v_mac(1, 0, 0, 1); v_act(FA_RELU, 0, 1);    v_busy();
    v_mac(2, 0, 0, 2); v_act(FA_SIGMOID, 0, 2); v_busy();
    v_mac(3, 0, 0, 3); v_act(FA_TANH, 0, 3);    v_busy();
    v_fim(); v_fim(); v_fim(); v_fim();
    cur_ok = 1'b0;
    v_fim(); v_idle();
    run_vecs("clamp");

    // Layers 0 (no neurons) and 1 (no inputs, no bias) skipped, layer 2 runs
    iDados = {13'd0, mk(1, 0, FA_RELU, 1), mk(1, 0, FA_LINEAR, 0), mk(0, 1, FA_SIGMOID, 3)};
    iQtdCamadas = 3'd3;
    start_rows();
    cur_ok = 1'b1;
    v_idle(); v_busy(); v_busy(); v_busy();
    v_mac(0, 0, 0, 2); v_act(FA_RELU, 0, 2);
    v_busy(); v_fim();
    run_vecs("skip");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
